// File: rtl/ext_loader_pkg.sv
// Shared opcodes, ack byte, FSM encoding and word-size helpers for the host loader.
`timescale 1ns/1ps
package ext_loader_pkg;

    localparam logic [7:0] OP_WR_INST  = 8'h01;
    localparam logic [7:0] OP_WR_PARAM = 8'h02;
    localparam logic [7:0] OP_WR_ACT   = 8'h03;
    localparam logic [7:0] OP_RD_ACT   = 8'h04;
    localparam logic [7:0] OP_RUN      = 8'h05;

    localparam logic [7:0] ACK_BYTE = 8'hA5;

    localparam int ASM_MAX_WIDTH = 128;
    localparam int ASM_CNT_W     = 5;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

    localparam int BPW_ACT   = bytes_per_word(8);
    localparam int BPW_PARAM = bytes_per_word(128);
    localparam int BPW_INST  = bytes_per_word(80);

    function automatic logic op_known(input logic [7:0] op);
        return (op >= OP_WR_INST) && (op <= OP_RUN);
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_WR_DATA,
        ST_WR_STROBE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_OUT,
        ST_RUN_START,
        ST_RUN,
        ST_RUN_ACK
    } state_e;

endpackage

// File: rtl/ext_host_loader_asm.sv
// Little-endian byte-to-word packer; word_done_o fires combinationally on the push that
// completes the word. No backpressure of its own: the caller gates push_i.
`timescale 1ns/1ps
module byte_word_assembler
    import ext_loader_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [7:0]               byte_i,
    input  logic [ASM_CNT_W-1:0]     nbytes_i,
    output logic [ASM_MAX_WIDTH-1:0] word_o,
    output logic                     word_done_o
);

    logic [ASM_CNT_W-1:0]     cnt_q;
    logic [ASM_MAX_WIDTH-1:0] word_q;

    assign word_o      = word_q;
    assign word_done_o = push_i && (cnt_q == nbytes_i - 1'b1);

    // Clearing only rewinds the counter; every byte lane is rewritten before the next strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (push_i) begin
            word_q[{cnt_q, 3'b000} +: 8] <= byte_i;
            cnt_q                        <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ext_host_loader.sv
// Byte-stream host loader: writes/reads processor memories and brackets a controller run.
// One word per (bytes+1) cycles; in_ready drops outside IDLE/HDR/WR_DATA, out_data holds until out_ready.
`timescale 1ns/1ps
module ext_host_loader
    import ext_loader_pkg::*;
#(
    parameter int WIDTH_ACT_MEM    = 8,
    parameter int WIDTH_PARAM_MEM  = 128,
    parameter int WIDTH_INST_MEM   = 80,
    parameter int WIDTH_ADDR_ACT   = 12,
    parameter int WIDTH_ADDR_PARAM = 13,
    parameter int WIDTH_ADDR_INST  = 6,
    parameter int RD_LAT           = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sel_ext,
    output logic                        en,
    output logic                        wea_instmem_ext,
    output logic                        wea_parammem_ext,
    output logic                        wea_actmem_ext,
    output logic [WIDTH_INST_MEM-1:0]   instmem_in_ext,
    output logic [WIDTH_PARAM_MEM-1:0]  parammem_in_ext,
    output logic [WIDTH_ACT_MEM-1:0]    actmem_in_ext,
    output logic [WIDTH_ADDR_INST-1:0]  addr_instmem_ext,
    output logic [WIDTH_ADDR_PARAM-1:0] addr_parammem_ext,
    output logic [WIDTH_ADDR_ACT-1:0]   addr_actmem_ext,
    input  logic [WIDTH_ACT_MEM-1:0]    actmem_out,
    input  logic                        done,
    output logic                        busy,
    output logic                        err
);

    localparam int B_ACT   = bytes_per_word(WIDTH_ACT_MEM);
    localparam int B_PARAM = bytes_per_word(WIDTH_PARAM_MEM);
    localparam int B_INST  = bytes_per_word(WIDTH_INST_MEM);

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  hidx_q, hidx_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] n_q, n_d;
    logic [15:0] k_q, k_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  rd_q, rd_d;
    logic        err_q, err_d;
    logic        live_q;
    logic        in_ready_c;

    logic                     asm_clr;
    logic                     asm_push;
    logic                     asm_done;
    logic [ASM_CNT_W-1:0]     asm_nbytes;
    logic [ASM_MAX_WIDTH-1:0] asm_word;

    byte_word_assembler u_asm (
        .clk_i       (clk),
        .rst_i       (reset),
        .clr_i       (asm_clr),
        .push_i      (asm_push),
        .byte_i      (in_data),
        .nbytes_i    (asm_nbytes),
        .word_o      (asm_word),
        .word_done_o (asm_done)
    );

    always_comb begin
        case (op_q)
            OP_WR_INST:  asm_nbytes = ASM_CNT_W'(B_INST);
            OP_WR_PARAM: asm_nbytes = ASM_CNT_W'(B_PARAM);
            default:     asm_nbytes = ASM_CNT_W'(B_ACT);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            hidx_q  <= '0;
            addr_q  <= '0;
            n_q     <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hidx_q  <= hidx_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        hidx_d           = hidx_q;
        addr_d           = addr_q;
        n_d              = n_q;
        k_d              = k_q;
        wait_d           = wait_q;
        rd_d             = rd_q;
        err_d            = err_q;
        in_ready_c       = 1'b0;
        out_valid        = 1'b0;
        sel_ext          = 1'b1;
        en               = 1'b0;
        wea_instmem_ext  = 1'b0;
        wea_parammem_ext = 1'b0;
        wea_actmem_ext   = 1'b0;
        asm_clr          = 1'b0;
        asm_push         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // live_q keeps in_ready low for the first cycle out of reset.
                in_ready_c = live_q;
                if (in_valid && live_q) begin
                    op_d    = in_data;
                    hidx_d  = '0;
                    k_d     = '0;
                    state_d = ST_HDR;
                    if (!op_known(in_data)) err_d = 1'b1;
                end
            end
            ST_HDR: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    case (hidx_q)
                        2'd0:    addr_d[15:8] = in_data;
                        2'd1:    addr_d[7:0]  = in_data;
                        2'd2:    n_d[15:8]    = in_data;
                        default: n_d[7:0]     = in_data;
                    endcase
                    hidx_d = hidx_q + 2'd1;
                    if (hidx_q == 2'd3) begin
                        asm_clr = 1'b1;
                        case (op_q)
                            OP_WR_INST, OP_WR_PARAM, OP_WR_ACT:
                                state_d = (n_d == 16'd0) ? ST_IDLE : ST_WR_DATA;
                            OP_RD_ACT:
                                state_d = (n_d == 16'd0) ? ST_IDLE : ST_RD_ADDR;
                            OP_RUN:  state_d = ST_RUN_START;
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_WR_DATA: begin
                in_ready_c = 1'b1;
                asm_push   = in_valid;
                if (asm_done) state_d = ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
                wea_instmem_ext  = (op_q == OP_WR_INST);
                wea_parammem_ext = (op_q == OP_WR_PARAM);
                wea_actmem_ext   = (op_q == OP_WR_ACT);
                asm_clr          = 1'b1;
                k_d              = k_q + 16'd1;
                addr_d           = addr_q + 16'd1;
                state_d          = (k_q + 16'd1 == n_q) ? ST_IDLE : ST_WR_DATA;
            end
            ST_RD_ADDR: begin
                wait_d  = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_q == 8'(RD_LAT - 1)) begin
                    rd_d    = actmem_out[7:0];
                    state_d = ST_RD_OUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_RD_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    k_d     = k_q + 16'd1;
                    addr_d  = addr_q + 16'd1;
                    state_d = (k_q + 16'd1 == n_q) ? ST_IDLE : ST_RD_ADDR;
                end
            end
            ST_RUN_START: begin
                sel_ext = 1'b0;
                en      = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                sel_ext = 1'b0;
                en      = 1'b1;
                if (done) state_d = ST_RUN_ACK;
            end
            ST_RUN_ACK: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[15:WIDTH_ADDR_PARAM];

    assign in_ready          = in_ready_c;
    assign out_data          = (state_q == ST_RUN_ACK) ? ACK_BYTE : rd_q;
    assign busy              = (state_q != ST_IDLE);
    assign err               = err_q;
    assign instmem_in_ext    = asm_word[WIDTH_INST_MEM-1:0];
    assign parammem_in_ext   = asm_word[WIDTH_PARAM_MEM-1:0];
    assign actmem_in_ext     = asm_word[WIDTH_ACT_MEM-1:0];
    assign addr_instmem_ext  = addr_q[WIDTH_ADDR_INST-1:0];
    assign addr_parammem_ext = addr_q[WIDTH_ADDR_PARAM-1:0];
    assign addr_actmem_ext   = addr_q[WIDTH_ADDR_ACT-1:0];

endmodule

// File: tb/tb_ext_host_loader.sv
// Randomized bench for ext_host_loader against a byte-stream command model and a 2-cycle memory.
`timescale 1ns/1ps
module tb_ext_host_loader;

    localparam logic [1:0] K_INST  = 2'd0;
    localparam logic [1:0] K_PARAM = 2'd1;
    localparam logic [1:0] K_ACT   = 2'd2;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid, in_ready;
    logic [7:0]   out_data;
    logic         out_valid, out_ready;
    logic         sel_ext, en, done, busy, err;
    logic         wea_instmem_ext, wea_parammem_ext, wea_actmem_ext;
    logic [79:0]  instmem_in_ext;
    logic [127:0] parammem_in_ext;
    logic [7:0]   actmem_in_ext;
    logic [5:0]   addr_instmem_ext;
    logic [12:0]  addr_parammem_ext;
    logic [11:0]  addr_actmem_ext;
    logic [7:0]   actmem_out;

    always #5 clk = ~clk;

    ext_host_loader dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_ext(sel_ext), .en(en),
        .wea_instmem_ext(wea_instmem_ext), .wea_parammem_ext(wea_parammem_ext),
        .wea_actmem_ext(wea_actmem_ext),
        .instmem_in_ext(instmem_in_ext), .parammem_in_ext(parammem_in_ext),
        .actmem_in_ext(actmem_in_ext),
        .addr_instmem_ext(addr_instmem_ext), .addr_parammem_ext(addr_parammem_ext),
        .addr_actmem_ext(addr_actmem_ext),
        .actmem_out(actmem_out), .done(done), .busy(busy), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]   kind;
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] mem     [4096];
    logic [7:0] ref_act [4096];
    logic [7:0] rd_d1, rd_d2;
    logic       err_exp = 1'b0;

    // Activation memory with two-cycle read latency.
    always @(posedge clk) begin
        if (wea_actmem_ext) mem[addr_actmem_ext] <= actmem_in_ext;
        rd_d1 <= mem[addr_actmem_ext];
        rd_d2 <= rd_d1;
    end
    assign actmem_out = rd_d2;

    always @(negedge clk) begin
        if (wea_instmem_ext || wea_parammem_ext || wea_actmem_ext)
            check_eq("wea_while_host_owned", sel_ext, 1);
        if (wea_instmem_ext)
            obs_q.push_back('{K_INST, 16'(addr_instmem_ext), 128'(instmem_in_ext)});
        if (wea_parammem_ext)
            obs_q.push_back('{K_PARAM, 16'(addr_parammem_ext), 128'(parammem_in_ext)});
        if (wea_actmem_ext)
            obs_q.push_back('{K_ACT, 16'(addr_actmem_ext), 128'(actmem_in_ext)});
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int         t    = 0;
        logic       seen = 1'b0;
        logic [7:0] held = 8'h00;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (seen) check_eq("out_stable", out_data, held);
                held = out_data;
                seen = 1'b1;
                if ($urandom_range(0, 1) == 1 || t > 8) begin
                    out_ready = 1'b1;
                    b = out_data;
                    @(posedge clk);
                    #1 out_ready = 1'b0;
                    return;
                end
            end
            t++;
            if (t > 1000) begin
                check_eq("out_valid_wait", out_valid, 1);
                return;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_eq("return_to_idle", busy, 0);
    endtask

    task automatic check_writes(input string tag);
        wr_t o, e;
        check_eq({tag, "_strobe_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check_eq({tag, "_kind"}, o.kind, e.kind);
            check_eq({tag, "_addr"}, o.addr, e.addr);
            check_eq({tag, "_data"}, o.data, e.data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_state();
        check_eq("rst_sel_ext", sel_ext, 1);
        check_eq("rst_en", en, 0);
        check_eq("rst_wea", {wea_instmem_ext, wea_parammem_ext, wea_actmem_ext}, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_data", {instmem_in_ext, actmem_in_ext, out_data}, 0);
        check_eq("rst_param_data", parammem_in_ext, 0);
        check_eq("rst_addr", {addr_instmem_ext, addr_parammem_ext, addr_actmem_ext}, 0);
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [15:0] n);
        int           bpw;
        logic [1:0]   kind;
        logic [15:0]  mask;
        logic [127:0] w;
        logic [7:0]   b;
        send_byte(op);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        if (op < 8'h01 || op > 8'h05) err_exp = 1'b1;
        case (op)
            8'h01:   begin bpw = 10; kind = K_INST;  mask = 16'h003F; end
            8'h02:   begin bpw = 16; kind = K_PARAM; mask = 16'h1FFF; end
            8'h03:   begin bpw = 1;  kind = K_ACT;   mask = 16'h0FFF; end
            default: begin bpw = 0;  kind = K_ACT;   mask = 16'h0000; end
        endcase
        if (bpw > 0) begin
            for (int k = 0; k < int'(n); k++) begin
                w = '0;
                for (int i = 0; i < bpw; i++) begin
                    b = (pay_q.size() > 0) ? pay_q.pop_front() : 8'($urandom);
                    w[i*8 +: 8] = b;
                    send_byte(b);
                end
                exp_q.push_back('{kind, (addr + 16'(k)) & mask, w});
                if (op == 8'h03) ref_act[12'(addr + 16'(k))] = w[7:0];
            end
        end
        if (op == 8'h04) begin
            for (int k = 0; k < int'(n); k++) begin
                recv_byte(b);
                check_eq("rd_data", b, ref_act[12'(addr + 16'(k))]);
            end
        end
        wait_idle();
        check_writes("wr");
        check_eq("err_flag", err, err_exp);
    endtask

    task automatic run_proc(input int d);
        logic [7:0] b;
        if (d == 0) done = 1'b1;
        send_byte(8'h05);
        repeat (4) send_byte(8'($urandom));
        @(negedge clk);
        check_eq("run_sel_ext", sel_ext, 0);
        check_eq("run_en", en, 1);
        if (d > 0) begin
            repeat (d - 1) @(negedge clk);
            check_eq("run_hold_en", {en, sel_ext}, 2'b10);
            done = 1'b1;
        end else begin
            @(negedge clk);
        end
        @(negedge clk);
        check_eq("post_done_en", en, 0);
        check_eq("post_done_sel_ext", sel_ext, 1);
        done = 1'b0;
        recv_byte(b);
        check_eq("run_ack", b, 8'hA5);
        wait_idle();
        check_writes("run");
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 8'($urandom);
            ref_act[i] = mem[i];
        end
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        pay_q = '{8'hAA, 8'hBB, 8'hCC};
        run_cmd(8'h03, 16'h0010, 16'd3);
        pay_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        run_cmd(8'h01, 16'h0025, 16'd1);
        run_cmd(8'h04, 16'h0FFF, 16'd2);
        run_proc(50);
        run_cmd(8'h7F, 16'($urandom), 16'($urandom));
        run_cmd(8'h03, 16'h0200, 16'd2);

        for (int it = 0; it < 40; it++) begin
            logic [15:0] a;
            logic [15:0] n;
            a = 16'($urandom);
            n = 16'($urandom_range(0, 3));
            case ($urandom_range(0, 6))
                0: run_cmd(8'h01, a, n);
                1: run_cmd(8'h02, a, n);
                2: run_cmd(8'h03, a, n);
                3: run_cmd(8'h04, a, n);
                4: run_cmd(8'($urandom_range(6, 255)), a, n);
                5: run_proc(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 8)));
                default: run_cmd(8'h04, a & 16'h0FFC, n);
            endcase
        end
        run_proc(0);

        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
        repeat (9) send_byte(8'($urandom));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state();
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        err_exp = 1'b0;
        check_eq("no_partial_strobe", 128'(obs_q.size()), 0);
        obs_q.delete();
        exp_q.delete();
        run_cmd(8'h02, 16'h1234, 16'd1);
        run_cmd(8'h04, 16'h0010, 16'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_host_loader.md
Name: ext_host_loader

Overview:
- Host-side counterpart of the processor's external memory-load port.
- Accepts a byte-stream command protocol (valid/ready) and from it:
  - writes the instruction, parameter and activation memories through the *_ext ports;
  - reads activation results back out as a byte stream;
  - hands memory ownership to the controller for a run, then reclaims it when done is seen.
- Sits between a host link (UART/FIFO bridge) and processor_top.

Parameters:
WIDTH_ACT_MEM, 8, activation word width (bytes/word = WIDTH_ACT_MEM/8)
WIDTH_PARAM_MEM, 128, parameter word width (16 bytes/word)
WIDTH_INST_MEM, 80, instruction word width (10 bytes/word)
WIDTH_ADDR_ACT, 12, activation address width
WIDTH_ADDR_PARAM, 13, parameter address width
WIDTH_ADDR_INST, 6, instruction address width
RD_LAT, 2, activation memory read latency in cycles (address to valid actmem_out)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_data  in  8  command/payload byte from host
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted when in_valid&in_ready
out_data  out  8  readback/ack byte to host
out_valid  out  1  out_data valid
out_ready  in  1  host accepts out_data
sel_ext  out  1  1 = host owns memories
en  out  1  controller enable
wea_instmem_ext  out  1  instruction memory write strobe
wea_parammem_ext  out  1  parameter memory write strobe
wea_actmem_ext  out  1  activation memory write strobe
instmem_in_ext  out  WIDTH_INST_MEM  instruction write data
parammem_in_ext  out  WIDTH_PARAM_MEM  parameter write data
actmem_in_ext  out  WIDTH_ACT_MEM  activation write data
addr_instmem_ext  out  WIDTH_ADDR_INST  instruction address
addr_parammem_ext  out  WIDTH_ADDR_PARAM  parameter address
addr_actmem_ext  out  WIDTH_ADDR_ACT  activation address
actmem_out  in  WIDTH_ACT_MEM  activation read data
done  in  1  controller done (level)
busy  out  1  not in IDLE
err  out  1  sticky: unknown opcode seen; cleared only by reset

Behaviour:
- Clocking/reset: single clock clk. Reset is asynchronous, active-high.
- Reset values:
  - sel_ext=1.
  - en=0, all wea_*=0, in_ready=0, out_valid=0, busy=0, err=0.
  - All data/address outputs = 0.
  - FSM returns to IDLE.
  - Reset mid-operation abandons the command; any partial word is discarded, not written.
- Header: 5 bytes, in order:
  - opcode;
  - start address [15:8], then [7:0];
  - word count N [15:8], then [7:0].
  - Address is truncated to the target's width; increments wrap modulo 2^WIDTH_ADDR.
- Opcodes:
  - 0x01 WR_INST, 0x02 WR_PARAM, 0x03 WR_ACT: N words of payload follow the header.
  - 0x04 RD_ACT: no payload; returns N bytes.
  - 0x05 RUN: address and count bytes are consumed but ignored.
  - Any other opcode: set err, consume the remaining 4 header bytes, return to IDLE, no memory access.
- N=0 on WR_*/RD_ACT: return to IDLE after the header; no strobe, no output.
- FSM states and transitions:
  - IDLE: in_ready=1. Opcode byte accepted -> HDR.
  - HDR: accept 4 bytes -> WR_DATA / RD_ADDR / RUN_START / IDLE.
  - WR_DATA: in_ready=1. Bytes fill the word little-endian (first byte -> bits[7:0]). After byte B=WIDTH/8 -> WR_STROBE.
  - WR_STROBE (1 cycle): in_ready=0; target wea=1 with addr=start+k and the data word; other wea=0. k++. If k==N -> IDLE, else WR_DATA. Each word produces exactly one strobe cycle.
  - RD_ADDR: drive addr_actmem_ext=start+k -> RD_WAIT.
  - RD_WAIT: count RD_LAT cycles, then capture actmem_out -> RD_OUT.
  - RD_OUT: out_valid=1 with the captured byte. out_data stays stable while out_ready=0. On handshake k++; if k==N -> IDLE, else RD_ADDR.
  - RUN_START: sel_ext=0, en=1 -> RUN.
  - RUN: hold en=1 until done=1 is sampled. Then en=0, sel_ext=1 the next cycle -> RUN_ACK. done already high on entry is still honoured; a zero-length run is legal.
  - RUN_ACK: out_valid=1, out_data=0xA5 until handshake -> IDLE.
- Write strobes are never asserted while sel_ext=0.
- in_ready=0 in every state except IDLE, HDR and WR_DATA.
- Throughput: one word per (B+1) cycles with back-to-back bytes; one read byte per RD_LAT+2 cycles minimum.

Decomposition:
- Package ext_loader_pkg holds:
  - opcode constants (OP_WR_INST..OP_RUN);
  - ACK byte 0xA5;
  - state encoding;
  - bytes-per-word localparams.
- One sub-module, byte_word_assembler: an up-to-WIDTH_PARAM_MEM-bit little-endian shift/pack register with byte counter, a clear input and a word_done flag.

Test Plan:
- WR_ACT: stream 03 00 10 00 03 AA BB CC -> three wea_actmem_ext pulses at addr 0x010/0x011/0x012 with data AA/BB/CC; sel_ext stays 1.
- WR_INST of 1 word, bytes 00..09 -> one wea_instmem_ext pulse, instmem_in_ext=0x09080706050403020100, addr as given; param and act strobes stay 0.
- RD_ACT at addr 0xFFF, N=2, memory model RD_LAT=2, out_ready toggled -> bytes from 0xFFF then 0x000 (wrap); out_data stable during stalls.
- RUN with done asserted 50 cycles later -> sel_ext=0 and en=1 for the run; en=0 and sel_ext=1 the cycle after done is sampled; then 0xA5 on out.
- Opcode 0x7F followed by 4 bytes -> err=1 sticky, no strobes; a following valid WR_ACT completes normally.
- Reset asserted mid-WR_PARAM after 9 payload bytes -> no strobe; outputs at reset values; a fresh command works afterwards.
